instr_fetch_queue: RTL

Instruction fetch front end for the Tomasulo MIPS core. Acts as the initiator on the instruction ROM read port: it drives `rom_nrd`/`rom_addr` from a program counter, captures the big-endian 32-bit word returned combinationally, and buffers fetched instructions with their PCs in a small queue. The issue stage drains the queue through a valid/ready handshake. Branch resolution redirects the PC and flushes the queue.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/instr_fifo.sv | 69 ++++++
 rtl/instr_fetch_queue.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the Tomasulo MIPS front end.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetched instructions with their PCs.
// Pointers wrap naturally; count carries one extra bit to tell full from empty.
module instr_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC, ROM read port, fetch queue, redirect.
// Define IFQ_BYPASS_EN to forward a fetched word straight to issue when the queue is empty.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0,
    parameter int              ROM_BYTES   = 100
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rom_nrd,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               issue_valid,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [ADDR_W-1:0]  issue_pc,
    input  logic               issue_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_done
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   pc_end;

    fetch_entry_t q_head, issue_entry;
    logic         q_full, q_empty, q_push, q_pop;
    logic [CW-1:0] q_count;
    logic         fetch_base, fetch, pop, byp;

    instr_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .wdata_i ({rom_data, pc_q}),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Widened so a PC near 2^32 still counts as past the end.
    assign pc_end     = {1'b0, pc_q} + (ADDR_W+1)'(3);
    assign fetch_done = (pc_end >= (ADDR_W+1)'(ROM_BYTES));

    always_comb begin
        fetch_base  = !rst && !redirect_valid && !fetch_done;
        issue_valid = (q_count != '0) && !redirect_valid;
        issue_entry = q_empty ? '0 : q_head;
        byp         = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (q_empty && fetch_base) begin
            byp         = 1'b1;
            issue_valid = 1'b1;
            issue_entry = {rom_data, pc_q};
        end
`endif
        pop    = issue_valid && issue_ready;
        fetch  = fetch_base && (!q_full || pop);
        q_push = fetch && !(byp && issue_ready);
        q_pop  = pop && !q_empty;
        pc_d   = pc_q;
        if (redirect_valid) pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        else if (fetch)     pc_d = pc_q + PC_STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign rom_nrd     = !fetch;
    assign rom_addr    = pc_q;
    assign issue_instr = issue_entry.instr;
    assign issue_pc    = issue_entry.pc;

endmodule
